// File: rtl/clk_div_ctrl.sv
// Runtime-configurable clock divider with glitch-free start/stop and divisor changes.
// Define CLK_DIV_CTRL_EDGE_CNT_EN to add the edge_cnt_o tick counter.
module clk_div_ctrl #(
    parameter int          DIV_W        = 16,
    parameter int unsigned DEFAULT_HALF = 49
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [DIV_W-1:0] cfg_half,
    output logic             gen_clk_o,
    output logic             tick_o,
    output logic             applied_o,
    output logic             running_o
`ifdef CLK_DIV_CTRL_EDGE_CNT_EN
    ,
    output logic [31:0]      edge_cnt_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PEND,
        S_STOP
    } state_e;

    state_e state_q, state_d;

    logic [DIV_W-1:0] count_q, count_d;
    logic [DIV_W-1:0] half_q, half_d;
    logic [DIV_W-1:0] shadow_q, shadow_d;
    logic             gen_q, gen_d;
    logic             tick_q, tick_d;
    logic             applied_q, applied_d;
    logic             accept, at_top, pe;

    assign accept = cfg_valid && cfg_ready;
    assign at_top = (count_q == half_q);
    // Full-period boundary: the last cycle of the low phase.
    assign pe     = at_top && !gen_q && (state_q != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (en) state_d = S_RUN;
            S_RUN: begin
                if (accept)   state_d = S_PEND;
                else if (!en) state_d = S_STOP;
            end
            S_PEND: if (pe) state_d = en ? S_RUN : S_IDLE;
            S_STOP: begin
                if (en)      state_d = S_RUN;
                else if (pe) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        running_o = (state_q != S_IDLE);
        cfg_ready = (state_q == S_IDLE) || (state_q == S_RUN);
    end

    always_comb begin
        count_d   = count_q;
        gen_d     = gen_q;
        half_d    = half_q;
        shadow_d  = shadow_q;
        applied_d = 1'b0;
        if (state_q == S_IDLE) begin
            count_d = '0;
            gen_d   = en;
            if (accept) begin
                half_d    = cfg_half;
                applied_d = 1'b1;
            end
        end else begin
            if (at_top) begin
                count_d = '0;
                gen_d   = !gen_q;
            end else begin
                count_d = count_q + DIV_W'(1);
            end
            if ((state_q == S_RUN) && accept) shadow_d = cfg_half;
            if ((state_q == S_PEND) && pe) begin
                half_d    = shadow_q;
                applied_d = 1'b1;
            end
            if (pe && (state_d == S_IDLE)) gen_d = 1'b0;
        end
        tick_d = gen_d && !gen_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            half_q    <= DIV_W'(DEFAULT_HALF);
            shadow_q  <= '0;
            gen_q     <= 1'b0;
            tick_q    <= 1'b0;
            applied_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            half_q    <= half_d;
            shadow_q  <= shadow_d;
            gen_q     <= gen_d;
            tick_q    <= tick_d;
            applied_q <= applied_d;
        end
    end

    assign gen_clk_o = gen_q;
    assign tick_o    = tick_q;
    assign applied_o = applied_q;

`ifdef CLK_DIV_CTRL_EDGE_CNT_EN
    logic [31:0] edge_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt_q <= '0;
        end else if (tick_d) begin
            edge_cnt_q <= edge_cnt_q + 32'd1;
        end
    end

    assign edge_cnt_o = edge_cnt_q;
`else
`endif

endmodule
